ahb_lite_master: RTL

//  Single-master AHB-Lite initiator: converts pipeline load/store requests (req/ack) into
//  AHB-Lite single NONSEQ transfers, drives address/control/wdata, and returns read data
//  or an error flag. Sits between the MIPS data-memory stage and the slave decoder/mux.

---
 rtl/ahb_lite_master_pkg.sv | 21 ++
 rtl/ahb_lite_master_if.sv | 34 +++
 rtl/ahb_lite_master.sv | 73 +++++++
 3 files changed

// File: rtl/ahb_lite_master_pkg.sv
// ahb_lite_master_pkg: AHB-Lite encodings and master FSM states,
// shared with the decoder and the slaves.
package ahb_lite_master_pkg;
    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR, ST_RESP} state_t;
    // Size 3 is reserved and always rejected.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        return (size == 2'd3) || (size == HSIZE_HALF[1:0] && lsb[0]) ||
               (size == HSIZE_WORD[1:0] && lsb != 2'b00);
    endfunction
endpackage

// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if: CPU request/response and AHB-Lite bus signals of the
// single-master initiator.
interface ahb_lite_master_if
    import ahb_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] haddr;
    htrans_t               htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_WIDTH-1:0] hwdata;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hready;
    logic                  hresp;
    modport master (
        input  req, we, addr, size, wdata, hrdata, hready, hresp,
        output ack, rdata, err, busy, haddr, htrans, hwrite, hsize, hwdata
    );
    modport slave (
        output req, we, addr, size, wdata, hrdata, hready, hresp,
        input  ack, rdata, err, busy, haddr, htrans, hwrite, hsize, hwdata
    );
endinterface

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: turns held CPU load/store requests into single NONSEQ
// AHB-Lite transfers and returns read data or an error with a one-cycle ack.
module ahb_lite_master
    import ahb_lite_master_pkg::*;
(
    input  logic              i_hclk,
    input  logic              i_hreset,
    ahb_lite_master_if.master bus
);
    state_t                       state;
    logic [$bits(bus.wdata)-1:0]  wdata_q;

    // Accept-cycle stall comes straight from req so the pipeline freezes at once.
    assign bus.busy = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_ERR) ||
                      (state == ST_IDLE && bus.req);

    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            state      <= ST_IDLE;
            wdata_q    <= '0;
            bus.htrans <= HT_IDLE;
            bus.haddr  <= '0;
            bus.hwrite <= 1'b0;
            bus.hsize  <= '0;
            bus.hwdata <= '0;
            bus.rdata  <= '0;
            bus.ack    <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.req) begin
                    if (misaligned(bus.size, bus.addr[1:0])) begin
                        state   <= ST_RESP;
                        bus.ack <= 1'b1;
                        bus.err <= 1'b1;
                    end else begin
                        state      <= ST_ADDR;
                        bus.htrans <= HT_NONSEQ;
                        bus.haddr  <= bus.addr;
                        bus.hwrite <= bus.we;
                        bus.hsize  <= {1'b0, bus.size};
                        wdata_q    <= bus.wdata;
                    end
                end
                ST_ADDR: if (bus.hready) begin
                    state      <= ST_DATA;
                    bus.htrans <= HT_IDLE;
                    bus.hwdata <= wdata_q;
                end
                ST_DATA: begin
                    if (bus.hready) begin
                        state   <= ST_RESP;
                        bus.ack <= 1'b1;
                        bus.err <= bus.hresp;
                        if (!bus.hwrite && bus.hresp == HRESP_OKAY)
                            bus.rdata <= bus.hrdata;
                    end else if (bus.hresp == HRESP_ERROR) begin
                        state <= ST_ERR;
                    end
                end
                ST_ERR: if (bus.hready) begin
                    state   <= ST_RESP;
                    bus.ack <= 1'b1;
                    bus.err <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    bus.ack <= 1'b0;
                end
            endcase
        end
    end
endmodule
